// File: rtl/rp_pio_cpl_tracker.sv
// Root Port PIO non-posted request tracker: tag allocation, completion decode and timeout.
// Optional macro RP_PIO_CPL_TIMEOUT_EN enables per-entry completion timers and CTO pulses.
module rp_pio_cpl_tracker #(
    parameter int NUM_TAGS   = 8,
    parameter int TAG_W      = 3,
    parameter int CTO_CYCLES = 50000,
    parameter int TMR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_type,
    output logic             req_ready,
    output logic [TAG_W-1:0] req_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [2:0]       cpl_status,
    input  logic             flush,
    output logic [31:0]      status_set,
    output logic             cpl_unexpected,
    output logic [TAG_W:0]   outstanding
);

    localparam int         SLOTS     = 1 << TAG_W;
    localparam logic [1:0] TYPE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        CPL_SC  = 3'b000,
        CPL_UR  = 3'b001,
        CPL_CRS = 3'b010,
        CPL_CA  = 3'b100
    } cpl_status_e;

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [1:0]          type_q [NUM_TAGS];
    logic [1:0]          type_d [NUM_TAGS];
    logic [31:0]         status_q, status_d;
    logic                unexp_q, unexp_d;

`ifdef RP_PIO_CPL_TIMEOUT_EN
    logic [TMR_W-1:0]    tmr_q [NUM_TAGS];
    logic [TMR_W-1:0]    tmr_d [NUM_TAGS];
`else
    logic [TMR_W-1:0]    unused_cto;
    assign unused_cto = TMR_W'(CTO_CYCLES);
`endif

    logic [SLOTS-1:0]    valid_slots;
    logic                cpl_hit;
    logic                cpl_is_ca;
    logic                cpl_is_ur;
    logic                req_fire;
    logic [4:0]          base;

    // Lowest-index free entry; depends only on registered valid bits.
    always_comb begin
        req_ready = 1'b0;
        req_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                req_ready = 1'b1;
                req_tag   = TAG_W'(i);
            end
        end
    end

    // Padding to the full tag space makes out-of-range tags read as unallocated.
    assign valid_slots = SLOTS'(valid_q);
    assign cpl_hit     = cpl_valid && valid_slots[cpl_tag];
    assign cpl_is_ca   = (cpl_status == CPL_CA);
    assign cpl_is_ur   = !(cpl_status inside {CPL_SC, CPL_CRS, CPL_CA});
    assign req_fire    = req_valid && req_ready && (req_type != TYPE_RSVD);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d  = valid_q;
        type_d   = type_q;
        status_d = '0;
        unexp_d  = 1'b0;
        base     = '0;
`ifdef RP_PIO_CPL_TIMEOUT_EN
        tmr_d    = tmr_q;
`endif
        if (flush) begin
            valid_d = '0;
`ifdef RP_PIO_CPL_TIMEOUT_EN
            for (int i = 0; i < NUM_TAGS; i++) tmr_d[i] = '0;
`endif
        end else begin
            unexp_d = cpl_valid && !cpl_hit;
            for (int i = 0; i < NUM_TAGS; i++) begin
                // Each type owns an 8-bit lane of the status register: {CTO, CA, UR}.
                base = {type_q[i], 3'b000};
                if (cpl_hit && cpl_tag == TAG_W'(i)) begin
                    valid_d[i] = 1'b0;
                    if (cpl_is_ca)      status_d[base + 5'd1] = 1'b1;
                    else if (cpl_is_ur) status_d[base]        = 1'b1;
                end
`ifdef RP_PIO_CPL_TIMEOUT_EN
                // Expire on the edge where the timer would reach CTO_CYCLES-1.
                else if (valid_q[i]) begin
                    if (tmr_q[i] == TMR_W'(CTO_CYCLES - 2)) begin
                        valid_d[i]            = 1'b0;
                        status_d[base + 5'd2] = 1'b1;
                    end else begin
                        tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    end
                end
`endif
                if (req_fire && req_tag == TAG_W'(i)) begin
                    valid_d[i] = 1'b1;
                    type_d[i]  = req_type;
`ifdef RP_PIO_CPL_TIMEOUT_EN
                    tmr_d[i]   = '0;
`endif
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking is kept for always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            status_q <= '0;
            unexp_q  <= 1'b0;
`ifdef RP_PIO_CPL_TIMEOUT_EN
            for (int i = 0; i < NUM_TAGS; i++) tmr_q[i] <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            status_q <= status_d;
            unexp_q  <= unexp_d;
`ifdef RP_PIO_CPL_TIMEOUT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

    // NOTE: the type array is not reset; it is only ever read when its valid bit is set.
    always_ff @(posedge clk) begin
        type_q <= type_d;
    end

    assign status_set     = status_q;
    assign cpl_unexpected = unexp_q;
    assign outstanding    = (TAG_W + 1)'($countones(valid_q));

endmodule

// File: tb/tb_rp_pio_cpl_tracker.sv
// Self-checking bench for rp_pio_cpl_tracker: directed scenarios plus random traffic
// against a deadline-based reference model of the tracker.
module tb_rp_pio_cpl_tracker;

    localparam int NT  = 8;
    localparam int TW  = 3;
    localparam int CTO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic [1:0]    req_type = '0;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic          cpl_valid = 1'b0;
    logic [TW-1:0] cpl_tag = '0;
    logic [2:0]    cpl_status = '0;
    logic          flush = 1'b0;
    logic [31:0]   status_set;
    logic          cpl_unexpected;
    logic [TW:0]   outstanding;

    rp_pio_cpl_tracker #(
        .NUM_TAGS   (NT),
        .TAG_W      (TW),
        .CTO_CYCLES (CTO),
        .TMR_W      (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_type       (req_type),
        .req_ready      (req_ready),
        .req_tag        (req_tag),
        .cpl_valid      (cpl_valid),
        .cpl_tag        (cpl_tag),
        .cpl_status     (cpl_status),
        .flush          (flush),
        .status_set     (status_set),
        .cpl_unexpected (cpl_unexpected),
        .outstanding    (outstanding)
    );

    always #5 clk = ~clk;

    // Reference model: per-tag busy flag, type and absolute deadline cycle.
    bit          m_busy [NT];
    int          m_type [NT];
    int          m_dead [NT];
    int          cyc = 0;
    logic [31:0] e_status;
    bit          e_unexp;
    int          e_out;
    bit          e_ready;
    int          e_tag;
    logic        o_ready;
    int          o_tag;
    int          n_checks = 0;
    int          n_pass = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic int status_offset(input logic [2:0] s);
        if (s == 3'b000 || s == 3'b010) return -1;
        if (s == 3'b100) return 1;
        return 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
        e_status = '0;
        e_unexp  = 1'b0;
        e_out    = 0;
    endfunction

    // One clock cycle: called and returns at posedge+1.
    task automatic tick(input bit rv, input logic [1:0] rt, input bit cv,
                        input logic [2:0] ct, input logic [2:0] cs, input bit fl);
        int off;
        e_ready = 1'b0;
        e_tag   = 0;
        for (int i = NT - 1; i >= 0; i--) if (!m_busy[i]) begin e_ready = 1'b1; e_tag = i; end
        req_valid = rv; req_type = rt; cpl_valid = cv; cpl_tag = ct; cpl_status = cs; flush = fl;
        @(negedge clk);
        o_ready = req_ready;
        o_tag   = int'(req_tag);
        @(posedge clk);
        e_status = '0;
        e_unexp  = 1'b0;
        if (fl) begin
            for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
        end else begin
            if (cv && m_busy[ct]) begin
                off = status_offset(cs);
                if (off >= 0) e_status[m_type[ct] * 8 + off] = 1'b1;
                m_busy[ct] = 1'b0;
            end else if (cv) begin
                e_unexp = 1'b1;
            end
`ifdef RP_PIO_CPL_TIMEOUT_EN
            for (int i = 0; i < NT; i++)
                if (m_busy[i] && m_dead[i] == cyc) begin
                    e_status[m_type[i] * 8 + 2] = 1'b1;
                    m_busy[i] = 1'b0;
                end
`endif
            if (rv && e_ready && rt != 2'd3) begin
                m_busy[e_tag] = 1'b1;
                m_type[e_tag] = int'(rt);
                m_dead[e_tag] = cyc + CTO - 1;
            end
        end
        cyc++;
        e_out = 0;
        for (int i = 0; i < NT; i++) e_out += int'(m_busy[i]);
        #1;
        req_valid = 1'b0; cpl_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
        n_checks++; if (req_tag !== '0) $display("FAIL reset_tag got=%0d exp=0", req_tag); else n_pass++;
        n_checks++; if (status_set !== 32'h0) $display("FAIL reset_status got=%h exp=0", status_set); else n_pass++;
        n_checks++; if (cpl_unexpected !== 1'b0) $display("FAIL reset_unexp got=%b exp=0", cpl_unexpected); else n_pass++;
        n_checks++; if (outstanding !== '0) $display("FAIL reset_outstanding got=%0d exp=0", outstanding); else n_pass++;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_cfg_ur();
        tick(1, 2'd0, 0, 0, 0, 0);
        n_checks++; if (o_tag != 0) $display("FAIL cfg_tag got=%0d exp=0", o_tag); else n_pass++;
        n_checks++; if (outstanding !== 4'd1) $display("FAIL cfg_out1 got=%0d exp=1", outstanding); else n_pass++;
        tick(0, 0, 1, 3'd0, 3'b001, 0);
        n_checks++; if (status_set !== 32'h0000_0001) $display("FAIL cfg_ur_status got=%h exp=00000001", status_set); else n_pass++;
        n_checks++; if (outstanding !== 4'd0) $display("FAIL cfg_out0 got=%0d exp=0", outstanding); else n_pass++;
        tick(0, 0, 0, 0, 0, 0);
        n_checks++; if (status_set !== 32'h0) $display("FAIL cfg_ur_one_cycle got=%h exp=0", status_set); else n_pass++;
    endtask

    task automatic test_fill_reuse();
        tick(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < NT; k++) begin
            tick(1, 2'd2, 0, 0, 0, 0);
            n_checks++; if (o_tag != k || o_ready !== 1'b1) $display("FAIL fill_tag got=%0d/%b exp=%0d/1", o_tag, o_ready, k); else n_pass++;
        end
        n_checks++; if (req_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", req_ready); else n_pass++;
        tick(1, 2'd2, 0, 0, 0, 0);
        n_checks++; if (o_ready !== 1'b0 || outstanding !== 4'd8) $display("FAIL full_hold got=%b/%0d exp=0/8", o_ready, outstanding); else n_pass++;
        tick(0, 0, 1, 3'd3, 3'b000, 0);
        n_checks++; if (status_set !== 32'h0 || outstanding !== 4'd7) $display("FAIL sc_free got=%h/%0d exp=0/7", status_set, outstanding); else n_pass++;
        n_checks++; if (req_ready !== 1'b1 || req_tag !== 3'd3) $display("FAIL reuse_ready got=%b/%0d exp=1/3", req_ready, req_tag); else n_pass++;
        tick(1, 2'd2, 0, 0, 0, 0);
        n_checks++; if (o_tag != 3 || outstanding !== 4'd8) $display("FAIL reuse_tag got=%0d/%0d exp=3/8", o_tag, outstanding); else n_pass++;
    endtask

    task automatic test_timeout();
        tick(0, 0, 0, 0, 0, 1);
        tick(1, 2'd1, 0, 0, 0, 0);
        for (int k = 1; k < CTO; k++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (k < CTO - 1) begin
                n_checks++; if (status_set !== 32'h0 || outstanding !== 4'd1) $display("FAIL cto_early k=%0d got=%h/%0d exp=0/1", k, status_set, outstanding); else n_pass++;
            end else begin
`ifdef RP_PIO_CPL_TIMEOUT_EN
                n_checks++; if (status_set !== 32'h0000_0400 || outstanding !== 4'd0) $display("FAIL cto_pulse got=%h/%0d exp=00000400/0", status_set, outstanding); else n_pass++;
`else
                n_checks++; if (status_set !== 32'h0 || outstanding !== 4'd1) $display("FAIL cto_disabled got=%h/%0d exp=0/1", status_set, outstanding); else n_pass++;
`endif
            end
        end
        tick(0, 0, 0, 0, 0, 0);
        n_checks++; if (status_set !== 32'h0) $display("FAIL cto_one_cycle got=%h exp=0", status_set); else n_pass++;
    endtask

    task automatic test_race();
        tick(0, 0, 0, 0, 0, 1);
        tick(1, 2'd2, 0, 0, 0, 0);
        for (int k = 1; k < CTO - 1; k++) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 3'd0, 3'b100, 0);
        n_checks++; if (status_set !== 32'h0002_0000 || outstanding !== 4'd0) $display("FAIL race_ca got=%h/%0d exp=00020000/0", status_set, outstanding); else n_pass++;
        tick(0, 0, 0, 0, 0, 0);
        n_checks++; if (status_set !== 32'h0) $display("FAIL race_no_cto got=%h exp=0", status_set); else n_pass++;
    endtask

    task automatic test_unexpected();
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 1, 3'd5, 3'b000, 0);
        n_checks++; if (cpl_unexpected !== 1'b1 || status_set !== 32'h0) $display("FAIL unexp_tag5 got=%b/%h exp=1/0", cpl_unexpected, status_set); else n_pass++;
        tick(1, 2'd0, 0, 0, 0, 0);
        n_checks++; if (cpl_unexpected !== 1'b0) $display("FAIL unexp_clear got=%b exp=0", cpl_unexpected); else n_pass++;
        tick(0, 0, 1, 3'd0, 3'b111, 0);
        n_checks++; if (status_set !== 32'h0000_0001 || cpl_unexpected !== 1'b0) $display("FAIL rsvd_status got=%h/%b exp=00000001/0", status_set, cpl_unexpected); else n_pass++;
        tick(1, 2'd3, 0, 0, 0, 0);
        n_checks++; if (o_ready !== 1'b1 || outstanding !== 4'd0) $display("FAIL type3_drop got=%b/%0d exp=1/0", o_ready, outstanding); else n_pass++;
    endtask

    task automatic test_flush_reset();
        tick(0, 0, 0, 0, 0, 1);
        tick(1, 2'd0, 0, 0, 0, 0);
        tick(1, 2'd1, 0, 0, 0, 0);
        tick(1, 2'd2, 0, 0, 0, 0);
        tick(1, 2'd0, 0, 0, 0, 0);
        n_checks++; if (outstanding !== 4'd4) $display("FAIL flush_pre got=%0d exp=4", outstanding); else n_pass++;
        tick(1, 2'd1, 1, 3'd1, 3'b001, 1);
        n_checks++; if (outstanding !== 4'd0 || status_set !== 32'h0 || cpl_unexpected !== 1'b0) $display("FAIL flush got=%0d/%h/%b exp=0/0/0", outstanding, status_set, cpl_unexpected); else n_pass++;
        tick(0, 0, 1, 3'd1, 3'b001, 0);
        n_checks++; if (cpl_unexpected !== 1'b1 || status_set !== 32'h0) $display("FAIL flush_late_cpl got=%b/%h exp=1/0", cpl_unexpected, status_set); else n_pass++;
        tick(1, 2'd0, 0, 0, 0, 0);
        tick(1, 2'd2, 0, 0, 0, 0);
        tick(0, 0, 1, 3'd0, 3'b001, 0);
        n_checks++; if (status_set !== 32'h0000_0001) $display("FAIL pre_reset_pulse got=%h exp=00000001", status_set); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (status_set !== 32'h0 || cpl_unexpected !== 1'b0 || outstanding !== '0 || req_ready !== 1'b1 || req_tag !== '0)
            $display("FAIL mid_reset got=%h/%b/%0d/%b/%0d exp=0/0/0/1/0", status_set, cpl_unexpected, outstanding, req_ready, req_tag);
        else n_pass++;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        tick(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            tick(($urandom % 3) != 0, 2'($urandom % 4), ($urandom % 2) == 1,
                 3'($urandom % NT), 3'($urandom % 8), ($urandom % 64) == 0);
            n_checks++; if (o_ready !== e_ready || (e_ready && o_tag != e_tag)) $display("FAIL rand_req n=%0d got=%b/%0d exp=%b/%0d", n, o_ready, o_tag, e_ready, e_tag); else n_pass++;
            n_checks++; if (status_set !== e_status) $display("FAIL rand_status n=%0d got=%h exp=%h", n, status_set, e_status); else n_pass++;
            n_checks++; if (cpl_unexpected !== e_unexp) $display("FAIL rand_unexp n=%0d got=%b exp=%b", n, cpl_unexpected, e_unexp); else n_pass++;
            n_checks++; if (int'(outstanding) != e_out) $display("FAIL rand_out n=%0d got=%0d exp=%0d", n, outstanding, e_out); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_cfg_ur();
        test_fill_reuse();
        test_timeout();
        test_race();
        test_unexpected();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rp_pio_cpl_tracker.md
# rp_pio_cpl_tracker

Tracks outstanding Root Port programmed-I/O (PIO) non-posted requests (Configuration, I/O, Memory read) from issue to completion. It allocates a tag per request and times out requests that receive no completion. It decodes completion status into one-cycle set pulses laid out bit-for-bit like the RP PIO Status register, so the `field_set` input of that RW1CS register connects to it directly. It sits between the root-port PIO request path and the RP PIO status/error-logging registers.

## Interface
- `NUM_TAGS`, default 8: number of tracker entries; 2..32.
- `TAG_W`, default 3: tag width; must equal clog2(`NUM_TAGS`).
- `CTO_CYCLES`, default 50000: completion-timeout limit in clk cycles; must be ≥ 2.
- `TMR_W`, default 16: width of each per-entry timer; must satisfy 2^`TMR_W` > `CTO_CYCLES`.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a PIO non-posted request is presented.
- `req_type` in 2: request type; 0=Cfg, 1=IO, 2=Mem, 3=reserved.
- `req_ready` out 1: a free entry exists; combinational from registered state only.
- `req_tag` out `TAG_W`: tag allocated when `req_valid && req_ready`; the lowest-index free entry.
- `cpl_valid` in 1: a completion for a PIO tag is presented; always accepted.
- `cpl_tag` in `TAG_W`: tag of the completion.
- `cpl_status` in 3: completion status; 000=SC, 001=UR, 010=CRS, 100=CA, others reserved.
- `flush` in 1: link-down/abort; discards all entries.
- `status_set` out 32: registered one-cycle set pulses. Cfg uses bits 2:0, IO uses bits 10:8, Mem uses bits 18:16, each as {CTO, CA, UR}. All other bits are always 0.
- `cpl_unexpected` out 1: registered pulse for a completion to a tag that is not allocated.
- `outstanding` out `TAG_W+1`: number of allocated entries.

## Operation
- Each entry holds a valid bit, a 2-bit type and a `TMR_W`-bit timer.
- **Allocate:** on `req_valid && req_ready` with `req_type` ≠ 3, the entry at `req_tag` sets valid, stores the type and clears its timer.
  - `req_type` = 3 is dropped: no allocation and no status, but handshake completes.
- **Complete:** on `cpl_valid` with an allocated `cpl_tag`, the entry is freed and `status_set` is pulsed the next cycle for the stored type:
  - SC or CRS: no bit set.
  - UR: UR bit.
  - CA: CA bit.
  - Reserved encodings: UR bit.
- **Unexpected completion:** `cpl_valid` to a tag that is not allocated pulses `cpl_unexpected`; there is no status pulse and no state change.
- **Timeout:** each valid entry's timer increments every cycle. An entry whose timer equals `CTO_CYCLES-1` is freed, and its type's CTO bit is pulsed. Several entries may expire in the same cycle; their bits are ORed.
- **Flush:** frees every entry and clears every timer. No status pulses are produced, and any completion or request in the same cycle is ignored.
- **Simultaneous events:**
  - Completion and timeout on the same entry in the same cycle: the completion wins and no CTO is pulsed.
  - Completion or timeout freeing entry N while a request is accepted: the new request uses the pre-existing free set, so N is reusable from the next cycle.
  - Events of different entries targeting the same status bit are ORed into one pulse.
- `outstanding` = (popcount of valid bits); updated one cycle after the event.

## Timing
- **Reset values:** all entries invalid, timers 0, `status_set`=0, `cpl_unexpected`=0, `outstanding`=0. `req_ready`=1 and `req_tag`=0 as soon as reset is asserted.
- **Reset mid-operation:** all entries discarded immediately; no pulses are produced.
- `req_ready` and `req_tag` are stable within a cycle and do not depend on `req_valid`, `cpl_valid` or `flush`.
- Completion accepted in cycle T → `status_set` pulse in cycle T+1, high for exactly one cycle.
- Allocation in cycle T with no completion → CTO pulse in cycle T+`CTO_CYCLES`.
- **Full:** `req_ready`=0 while all `NUM_TAGS` entries are valid. It returns to 1 the cycle after any entry is freed.
- Timers never wrap: an entry is freed at the limit.

## Configuration
- Macro `RP_PIO_CPL_TIMEOUT_EN`.
- **Defined:** per-entry timers and CTO pulses operate as described.
- **Undefined:**
  - Timers are not implemented.
  - Entries are freed only by completion or flush.
  - `status_set` bits 2, 10 and 18 are constant 0.
  - `CTO_CYCLES` and `TMR_W` are unused.

## Test plan
- **Reset then Cfg UR:** reset; Cfg request (tag 0); completion tag 0 status 001 → `status_set`=32'h0000_0001 for one cycle, `outstanding` 1→0.
- **Fill and reuse:** 8 Mem requests → tags 0..7, `req_ready`=0. Completion tag 3 SC → no status. Next request gets tag 3.
- **Timeout:** `CTO_CYCLES`=20; IO request at cycle T, no completion → `status_set`=32'h0000_0400 at T+20, entry freed. With the macro undefined: no pulse and `outstanding` stays 1.
- **Completion racing timeout:** completion CA arrives in the same cycle the timer hits 19 → `status_set`=32'h0002_0000 for a Mem entry, with bit 18 clear.
- **Unexpected and reserved status:** completion to free tag 5 → `cpl_unexpected`=1, `status_set`=0. Completion status 111 to a Cfg entry → bit 0 set.
- **Flush and reset mid-flight:** 4 outstanding entries, then `flush` → `outstanding`=0, no pulses, a later completion to tag 1 is unexpected. Asserting `rst_n` low with entries pending → all outputs return to their reset values immediately.
